// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin arbiter time-sharing one external unsigned N x N multiplier among NREQ requesters.
// Latency: 2 cycles from request handshake to rsp_valid; one product per cycle while rsp_ready stays high.
// Backpressure: rsp_ready low freezes S2, then S1; req_ready drops to zero once both stages are full.
// Optional build macro MUL_SHARE_ARB_PERF_EN adds cnt_clr and per-requester saturating grant counters (grant_cnt).
// Parameter legality (N a multiple of 4 and >= 4, NREQ in 2..8) is the integrator's responsibility.
module mul_share_arb #(
  parameter  int N    = 8,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*N-1:0]    req_a,
  input  logic [NREQ*N-1:0]    req_b,
  output logic [N-1:0]         mul_a,
  output logic [N-1:0]         mul_b,
  input  logic [2*N-1:0]       mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [2*N-1:0]       rsp_p,
`ifdef MUL_SHARE_ARB_PERF_EN
  input  logic                 cnt_clr,
  output logic [NREQ*16-1:0]   grant_cnt,
`endif
  output logic                 busy
);

  // Round-robin pointer: the requester searched first next time.
  logic [IDW-1:0]  ptr;
  // S1 bookkeeping (operands themselves live in mul_a / mul_b).
  logic            s1_v;
  logic [IDW-1:0]  s1_id;

  logic            s2_acc;
  logic            s1_acc;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            hs;

  // Stage acceptance chain: S2 frees when empty or drained, S1 frees when empty or S2 frees.
  always_comb begin
    s2_acc = !rsp_valid | rsp_ready;
    s1_acc = !s1_v | s2_acc;
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_any && req_valid[(int'(ptr) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(ptr) + k) % NREQ);
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  // Handshake and ready; ready is forced low while reset is asserted.
  always_comb begin
    hs        = gnt_any & s1_acc;
    req_ready = grant & {NREQ{s1_acc & rst_n}};
    busy      = s1_v | rsp_valid;
  end

  // S1: capture granted operands; operands hold their last value when idle to avoid toggling the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_id <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (s1_acc) begin
      s1_v <= hs;
      if (hs) begin
        s1_id <= gnt_id;
        mul_a <= req_a[int'(gnt_id)*N +: N];
        mul_b <= req_b[int'(gnt_id)*N +: N];
        ptr   <= (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  // S2: register the product when S1 is full and S2 can take it; empties on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
    end else if (s2_acc) begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_id <= s1_id;
        rsp_p  <= mul_p;
      end
    end
  end

`ifdef MUL_SHARE_ARB_PERF_EN
  // Per-requester grant counters, saturating; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (cnt_clr) begin
      grant_cnt <= '0;
    end else if (hs && grant_cnt[int'(gnt_id)*16 +: 16] != 16'hFFFF) begin
      grant_cnt[int'(gnt_id)*16 +: 16] <= grant_cnt[int'(gnt_id)*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Testbench for mul_share_arb: directed vectors, multi-cycle corner sequences, randomized traffic.
// Reference model: in-flight queue of {id, a*b, handshake edge} plus round-robin pointer.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_mul_share_arb;
  localparam int N    = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [N-1:0]      mul_a;
  logic [N-1:0]      mul_b;
  logic [2*N-1:0]    mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*N-1:0]    rsp_p;
  logic              busy;
`ifdef MUL_SHARE_ARB_PERF_EN
  logic              cnt_clr;
  logic [NREQ*16-1:0] grant_cnt;
`endif

  mul_share_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p),
`ifdef MUL_SHARE_ARB_PERF_EN
    .cnt_clr(cnt_clr), .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  // The shared combinational multiplier living outside the block.
  assign mul_p = {8'h00, mul_a} * {8'h00, mul_b};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int p;
    int e;
  } exp_t;

  exp_t            expq[$];
  int              cyc = 0;
  int              model_ptr = 0;
  logic [NREQ-1:0] hs_last = '0;

  always @(negedge clk) begin : mon
    bit   ev;
    bit   acc;
    int   g;
    int   idx;
    logic [NREQ-1:0] exp_rdy;
    exp_t ne;
    cyc++;
    if (!rst_n) begin
      expq.delete();
      model_ptr = 0;
      hs_last   = '0;
    end else begin
      // Head of the in-flight queue is visible one edge after its handshake edge.
      ev = (expq.size() > 0) && (cyc >= expq[0].e + 1);
      check("mon_rsp_valid", 32'(rsp_valid), 32'(ev));
      check("mon_busy", 32'(busy), 32'(expq.size() > 0));
      if (ev && rsp_valid) begin
        check("mon_rsp_id", 32'(rsp_id), 32'(expq[0].id));
        check("mon_rsp_p", 32'(rsp_p), 32'(expq[0].p));
      end
      // At most two in flight; a full pipe only accepts while the consumer drains.
      acc = (expq.size() < 2) || rsp_ready;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        idx = (model_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (acc && g >= 0) exp_rdy[g] = 1'b1;
      check("mon_req_ready", 32'(req_ready), 32'(exp_rdy));
      hs_last = req_valid & req_ready;
      if (ev && rsp_valid && rsp_ready) void'(expq.pop_front());
      for (int i = 0; i < NREQ; i++) begin
        if (hs_last[i]) begin
          ne.id = i;
          ne.p  = int'(req_a[i*N +: N]) * int'(req_b[i*N +: N]);
          ne.e  = cyc + 1;
          expq.push_back(ne);
          model_ptr = (i + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    int id;
    int a;
    int b;
    int p;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs_n;
    int got;
    int order[$];
    int rsp_ids[$];
    int rsp_ps[$];
    logic [2*N-1:0] held_p;
    logic [IDW-1:0] held_id;
    int ops_a[NREQ];
    int ops_b[NREQ];

    vecs[0] = '{0, 8'h00, 8'hAB, 16'h0000};
    vecs[1] = '{1, 8'h01, 8'hFF, 16'h00FF};
    vecs[2] = '{2, 8'h80, 8'h80, 16'h4000};
    vecs[3] = '{3, 8'hFF, 8'hFE, 16'hFD02};
    vecs[4] = '{1, 8'hFF, 8'hFF, 16'hFE01};

    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
`ifdef MUL_SHARE_ARB_PERF_EN
    cnt_clr = 1'b0;
`endif
    #1;
    // Reset values.
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    check("rst_mul_b", 32'(mul_b), 0);
    check("rst_rsp_p", 32'(rsp_p), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin fairness with all four requesting continuously.
    tick();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = N'(i + 3);
      req_b[i*N +: N] = 8'h10;
    end
    req_valid = 4'hF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
      if (n >= 2) begin
        check("rr_rsp_valid", 32'(rsp_valid), 1);
        check("rr_rsp_id", 32'(rsp_id), 32'((n - 2) % 4));
        check("rr_rsp_p", 32'(rsp_p), 32'(16'h0030 + 16'h0010 * ((n - 2) % 4)));
      end
    end
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Single request, latency.
    req_a[2*N +: N] = 8'hFF;
    req_b[2*N +: N] = 8'hFF;
    req_valid = 4'b0100;
    @(negedge clk);
    check("lat_req_ready", 32'(req_ready), 32'(4'b0100));
    tick();
    req_valid = '0;
    @(negedge clk);
    check("lat_mul_a", 32'(mul_a), 32'hFF);
    check("lat_rsp_valid_k", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    check("lat_rsp_valid_k1", 32'(rsp_valid), 1);
    check("lat_rsp_id", 32'(rsp_id), 2);
    check("lat_rsp_p", 32'(rsp_p), 32'hFE01);
    tick();
    @(negedge clk);
    check("lat_idle_mul_a_hold", 32'(mul_a), 32'hFF);
    tick();

    // Table of boundary operands.
    foreach (vecs[v]) begin
      req_a[vecs[v].id*N +: N] = N'(vecs[v].a);
      req_b[vecs[v].id*N +: N] = N'(vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      got = 0;
      for (int t = 0; t < 10 && got == 0; t++) begin
        @(negedge clk);
        if (req_ready[vecs[v].id]) got = 1;
        tick();
      end
      check("vec_accepted", 32'(got), 1);
      req_valid = '0;
      got = 0;
      for (int t = 0; t < 10 && got == 0; t++) begin
        @(negedge clk);
        if (rsp_valid) begin
          got = 1;
          check("vec_rsp_p", 32'(rsp_p), 32'(vecs[v].p));
          check("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
        end
        tick();
      end
      check("vec_rsp_seen", 32'(got), 1);
    end
    repeat (2) tick();

    // Backpressure: consumer stalled for 5 cycles, three requesters active.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ops_a[i] = 8'h11 * (i + 1);
      ops_b[i] = 8'h20 + i;
      req_a[i*N +: N] = N'(ops_a[i]);
      req_b[i*N +: N] = N'(ops_b[i]);
    end
    req_valid = 4'b0111;
    hs_n = 0;
    held_p = '0;
    held_id = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin
        hs_n++;
        order.push_back(i);
      end
      if (c >= 2) check("bp_ready_zero", 32'(req_ready), 0);
      if (c == 2) begin
        held_p = rsp_p;
        held_id = rsp_id;
      end
      if (c > 2) begin
        check("bp_rsp_p_stable", 32'(rsp_p), 32'(held_p));
        check("bp_rsp_id_stable", 32'(rsp_id), 32'(held_id));
      end
      tick();
      req_valid = req_valid & ~hs_last;
    end
    check("bp_handshakes", 32'(hs_n), 2);
    rsp_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_ps.push_back(int'(rsp_p));
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) order.push_back(i);
      tick();
      req_valid = req_valid & ~hs_last;
    end
    check("bp_rsp_count", 32'(rsp_ids.size()), 3);
    check("bp_grant_count", 32'(order.size()), 3);
    if (rsp_ids.size() == 3 && order.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("bp_order_id", 32'(rsp_ids[k]), 32'(order[k]));
        check("bp_order_p", 32'(rsp_ps[k]), 32'(ops_a[order[k]] * ops_b[order[k]]));
      end
    end

    // Reset mid-flight with both stages full.
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    repeat (3) tick();
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 1);
    check("mid_rsp_valid_before", 32'(rsp_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_mul_a", 32'(mul_a), 0);
    check("mid_rst_rsp_p", 32'(rsp_p), 0);
    check("mid_rst_rsp_id", 32'(rsp_id), 0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_first_grant", 32'(req_ready), 32'(4'b0010));
    check("mid_no_stale_rsp0", 32'(rsp_valid), 0);
    tick();
    req_valid = '0;
    @(negedge clk);
    check("mid_no_stale_rsp1", 32'(rsp_valid), 0);
    tick();
    @(negedge clk);
    check("mid_new_rsp_valid", 32'(rsp_valid), 1);
    check("mid_new_rsp_id", 32'(rsp_id), 1);
    repeat (2) tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_last[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_a[i*N +: N] = ($urandom_range(0, 7) == 0) ? 8'hFF : N'($urandom);
          req_b[i*N +: N] = ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    req_valid = req_valid & ~hs_last;
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && req_valid != 0; t++) begin
      tick();
      req_valid = req_valid & ~hs_last;
    end
    for (int t = 0; t < 10 && expq.size() > 0; t++) @(negedge clk);
    check("rand_drained", 32'(expq.size()), 0);

`ifdef MUL_SHARE_ARB_PERF_EN
    // Grant counters: saturation and clear-over-increment.
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("perf_cleared", 32'(grant_cnt[31:0]) | 32'(grant_cnt[63:32]), 0);
    req_a[1*N +: N] = 8'h05;
    req_b[1*N +: N] = 8'h07;
    req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    check("perf_sat_1", 32'(grant_cnt[1*16 +: 16]), 32'hFFFF);
    check("perf_other_0", 32'(grant_cnt[0*16 +: 16]), 0);
    check("perf_other_2", 32'(grant_cnt[2*16 +: 16]), 0);
    tick();
    cnt_clr = 1'b1;
    @(negedge clk);
    check("perf_clr_with_grant", 32'(req_ready), 32'(4'b0010));
    tick();
    cnt_clr = 1'b0;
    req_valid = '0;
    @(negedge clk);
    check("perf_clr_result", 32'(grant_cnt[1*16 +: 16]), 0);
    repeat (3) tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
